// File: rtl/wb_load_return_pkg.sv
// Shared RV32I types used by the writeback / load-return path.
package rv32i_types;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_t;

  // funct3 is kept raw so an illegal encoding survives until the pop.
  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } ld_meta_t;

endpackage

// File: rtl/wb_ld_fifo.sv
// In-order tracker of outstanding loads; exposes every entry plus its valid bit.
module wb_ld_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ld_meta_t                 din,
  input  logic                     pop,
  output ld_meta_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         vld,
  output ld_meta_t [DEPTH-1:0]     ents
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ld_meta_t [DEPTH-1:0] mem;
  logic [AW-1:0]        wptr, rptr;
  logic                 do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  assign ents    = mem;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      if (do_push) begin
        wptr      <= wptr + 1'b1;
        vld[wptr] <= 1'b1;
      end
      if (do_pop) begin
        rptr      <= rptr + 1'b1;
        vld[rptr] <= 1'b0;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_load_return.sv
// Writeback unit: tracks non-blocking loads, aligns/extends returned data and
// arbitrates load returns against ALU results onto the single write port.
module wb_load_return
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [4:0]              ld_rd,
  input  logic [2:0]              ld_funct3,
  input  logic [1:0]              ld_addr_lo,
  input  logic                    dmem_resp,
  input  logic [XLEN-1:0]         dmem_rdata,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  output logic                    regf_we,
  output logic [4:0]              rd_sel,
  output logic [XLEN-1:0]         rd_v,
  output logic [31:0]             busy_rd,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    resp_err
);

  ld_meta_t             push_meta, head;
  ld_meta_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0]     ent_vld;
  logic                 full, empty, push, pop, alu_acc, bad_f3;
  logic [31:0]          w32, busy;
  logic [15:0]          half_v;
  logic [7:0]           byte_v;
  logic [XLEN-1:0]      ld_data;

  assign push_meta = '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};
  assign ld_ready  = !full;
  assign push      = ld_valid && ld_ready;
  assign pop       = dmem_resp && !empty;
  assign alu_ready = !dmem_resp;
  assign alu_acc   = alu_valid && alu_ready;

  wb_ld_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_meta),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding),
    .vld   (ent_vld),
    .ents  (ents)
  );

  assign w32    = dmem_rdata[31:0];
  assign byte_v = 8'(w32 >> {head.addr_lo, 3'b000});
  assign half_v = head.addr_lo[1] ? w32[31:16] : w32[15:0];

  always_comb begin
    ld_data = '0;
    bad_f3  = 1'b0;
    case (head.funct3)
      F3_LB:   ld_data = XLEN'($signed(byte_v));
      F3_LBU:  ld_data = XLEN'(byte_v);
      F3_LH:   ld_data = XLEN'($signed(half_v));
      F3_LHU:  ld_data = XLEN'(half_v);
      F3_LW:   ld_data = XLEN'($signed(w32));
      default: bad_f3  = 1'b1;
    endcase
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) busy[ents[i].rd] = 1'b1;
    busy[0] = 1'b0;
  end
  assign busy_rd = busy;

  // Load return wins the write port; x0 destinations never assert the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      regf_we  <= 1'b0;
      rd_sel   <= '0;
      rd_v     <= '0;
      resp_err <= 1'b0;
    end else begin
      regf_we <= 1'b0;
      if (pop) begin
        if (bad_f3) resp_err <= 1'b1;
        if (head.rd != 5'd0) begin
          regf_we <= 1'b1;
          rd_sel  <= head.rd;
          rd_v    <= ld_data;
        end
      end else if (alu_acc && alu_rd != 5'd0) begin
        regf_we <= 1'b1;
        rd_sel  <= alu_rd;
        rd_v    <= alu_data;
      end
      if (dmem_resp && empty) resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_load_return.sv
// Self-checking bench: directed scenarios plus random traffic vs a queue model.
module tb_wb_load_return;
  import rv32i_types::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0, rst = 1'b0;
  logic            ld_valid = 1'b0, ld_ready;
  logic [4:0]      ld_rd = '0;
  logic [2:0]      ld_funct3 = '0;
  logic [1:0]      ld_addr_lo = '0;
  logic            dmem_resp = 1'b0;
  logic [XLEN-1:0] dmem_rdata = '0;
  logic            alu_valid = 1'b0, alu_ready;
  logic [4:0]      alu_rd = '0;
  logic [XLEN-1:0] alu_data = '0;
  logic            regf_we;
  logic [4:0]      rd_sel;
  logic [XLEN-1:0] rd_v;
  logic [31:0]     busy_rd;
  logic [CW-1:0]   outstanding;
  logic            resp_err;

  wb_load_return #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .regf_we(regf_we), .rd_sel(rd_sel), .rd_v(rd_v),
    .busy_rd(busy_rd), .outstanding(outstanding), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct { int rd; int f3; int lo; } ld_t;
  ld_t         mq[$];
  bit          m_err;
  bit          exp_we;
  logic [4:0]  exp_sel;
  logic [31:0] exp_v;
  int          n_checks = 0, n_pass = 0;

  function automatic logic [31:0] m_ext(int f3, int lo, logic [31:0] d, output bit ok);
    int b, h;
    b  = int'((d >> (8 * lo)) & 32'hFF);
    h  = int'((d >> (16 * (lo / 2))) & 32'hFFFF);
    ok = 1'b1;
    case (f3)
      0: return (b >= 128) ? b - 256 : b;
      1: return (h >= 32768) ? h - 65536 : h;
      2: return d;
      4: return b;
      5: return h;
      default: begin ok = 1'b0; return 0; end
    endcase
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] m = '0;
    foreach (mq[i]) if (mq[i].rd != 0) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  // Advance one clock, updating the model from the inputs presented this cycle.
  task automatic cycle();
    bit ok, acc;
    ld_t e;
    logic [31:0] v;
    acc = ld_valid && (mq.size() < DEPTH);
    if (rst) begin
      mq.delete(); m_err = 0; exp_we = 0; exp_sel = '0; exp_v = '0;
    end else begin
      exp_we = 0;
      if (dmem_resp) begin
        if (mq.size() == 0) m_err = 1;
        else begin
          e = mq.pop_front();
          v = m_ext(e.f3, e.lo, dmem_rdata, ok);
          if (!ok) m_err = 1;
          if (e.rd != 0) begin exp_we = 1; exp_sel = 5'(e.rd); exp_v = v; end
        end
      end else if (alu_valid && alu_rd != 0) begin
        exp_we = 1; exp_sel = alu_rd; exp_v = alu_data;
      end
      if (acc) mq.push_back('{rd: int'(ld_rd), f3: int'(ld_funct3), lo: int'(ld_addr_lo)});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ld_valid = 0; dmem_resp = 0; alu_valid = 0; rst = 0;
  endtask

  task automatic issue(int rd, int f3, int lo);
    ld_valid = 1; ld_rd = 5'(rd); ld_funct3 = 3'(f3); ld_addr_lo = 2'(lo);
    cycle(); ld_valid = 0;
  endtask

  task automatic respond(logic [31:0] d);
    dmem_resp = 1; dmem_rdata = d;
    cycle(); dmem_resp = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset(); cycle();
    n_checks++;
    if ({regf_we, rd_sel, rd_v, busy_rd, outstanding, resp_err} !== '0)
      $display("FAIL reset_state got we=%b sel=%0d v=%h busy=%h out=%0d err=%b want all 0",
               regf_we, rd_sel, rd_v, busy_rd, outstanding, resp_err);
    else n_pass++;
    n_checks++;
    if (ld_ready !== 1'b1) $display("FAIL reset_ld_ready got %b want 1", ld_ready);
    else n_pass++;
  endtask

  task automatic test_lb_lbu();
    issue(5, 0, 3); respond(32'h80FF_FF12);
    n_checks++;
    if ({regf_we, rd_sel, rd_v} !== {1'b1, 5'd5, 32'hFFFF_FF80})
      $display("FAIL lb_sext got we=%b sel=%0d v=%h want 1/5/ffffff80", regf_we, rd_sel, rd_v);
    else n_pass++;
    cycle();
    n_checks++;
    if (regf_we !== 1'b0) $display("FAIL we_one_cycle got %b want 0", regf_we);
    else n_pass++;
    issue(5, 4, 3); respond(32'h80FF_FF12);
    n_checks++;
    if ({regf_we, rd_sel, rd_v} !== {1'b1, 5'd5, 32'h0000_0080})
      $display("FAIL lbu_zext got we=%b sel=%0d v=%h want 1/5/00000080", regf_we, rd_sel, rd_v);
    else n_pass++;
  endtask

  task automatic test_in_order();
    logic [31:0] rdata [3];
    logic [31:0] want  [3];
    rdata = '{32'h8001_2345, 32'hDEAD_BEEF, 32'h0000_F00D};
    want  = '{32'hFFFF_8001, 32'hDEAD_BEEF, 32'h0000_F00D};
    issue(7, 1, 2); issue(8, 2, 0); issue(9, 5, 0);
    n_checks++;
    if (busy_rd !== 32'h0000_0380 || outstanding !== CW'(3))
      $display("FAIL busy_three got busy=%h out=%0d want 00000380/3", busy_rd, outstanding);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      respond(rdata[i]);
      n_checks++;
      if ({regf_we, rd_sel, rd_v} !== {1'b1, 5'(7 + i), want[i]})
        $display("FAIL in_order_%0d got we=%b sel=%0d v=%h want 1/%0d/%h",
                 i, regf_we, rd_sel, rd_v, 7 + i, want[i]);
      else n_pass++;
    end
    n_checks++;
    if (busy_rd !== 32'h0 || outstanding !== CW'(0))
      $display("FAIL busy_drained got busy=%h out=%0d want 0/0", busy_rd, outstanding);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) issue(10 + i, 2, 0);
    n_checks++;
    if (ld_ready !== 1'b0 || outstanding !== CW'(4))
      $display("FAIL full got ready=%b out=%0d want 0/4", ld_ready, outstanding);
    else n_pass++;
    ld_valid = 1; ld_rd = 5'd14; ld_funct3 = 3'd2;
    dmem_resp = 1; dmem_rdata = 32'h1111_2222;
    cycle(); idle();
    n_checks++;
    if (ld_ready !== 1'b1 || outstanding !== CW'(3) || rd_sel !== 5'd10)
      $display("FAIL full_no_bypass got ready=%b out=%0d sel=%0d want 1/3/10",
               ld_ready, outstanding, rd_sel);
    else n_pass++;
    for (int i = 0; i < 3; i++) respond(32'(i));
    for (int i = 0; i < 10; i++) begin
      issue(i + 1, 2, 0); issue(i + 20, 4, i % 4);
      respond(32'h0101_0101 * i);
      n_checks++;
      if ({regf_we, rd_sel, rd_v} !== {1'b1, 5'(i + 1), 32'h0101_0101 * i})
        $display("FAIL wrap_%0d got sel=%0d v=%h want %0d/%h", i, rd_sel, rd_v, i + 1, 32'h0101_0101 * i);
      else n_pass++;
      respond(32'hA5A5_A5A5);
      n_checks++;
      if (rd_v !== 32'h0000_00A5 || rd_sel !== 5'(i + 20))
        $display("FAIL wrap_lbu_%0d got sel=%0d v=%h want %0d/000000a5", i, rd_sel, rd_v, i + 20);
      else n_pass++;
    end
  endtask

  task automatic test_arb();
    issue(20, 2, 0);
    dmem_resp = 1; dmem_rdata = 32'h1234_5678;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h55;
    #1;
    n_checks++;
    if (alu_ready !== 1'b0) $display("FAIL arb_alu_ready got %b want 0", alu_ready);
    else n_pass++;
    cycle(); dmem_resp = 0; #1;
    n_checks++;
    if ({regf_we, rd_sel, rd_v, alu_ready} !== {1'b1, 5'd20, 32'h1234_5678, 1'b1})
      $display("FAIL arb_load_first got sel=%0d v=%h alu_ready=%b want 20/12345678/1",
               rd_sel, rd_v, alu_ready);
    else n_pass++;
    cycle(); alu_valid = 0;
    n_checks++;
    if ({regf_we, rd_sel, rd_v} !== {1'b1, 5'd3, 32'h55})
      $display("FAIL arb_alu_write got we=%b sel=%0d v=%h want 1/3/55", regf_we, rd_sel, rd_v);
    else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    issue(6, 3, 0); respond(32'hFFFF_FFFF);
    n_checks++;
    if ({regf_we, rd_sel, rd_v, resp_err} !== {1'b1, 5'd6, 32'h0, 1'b1})
      $display("FAIL illegal_f3 got we=%b sel=%0d v=%h err=%b want 1/6/0/1",
               regf_we, rd_sel, rd_v, resp_err);
    else n_pass++;
    do_reset();
    respond(32'hAA);
    n_checks++;
    if (regf_we !== 1'b0 || resp_err !== 1'b1)
      $display("FAIL empty_resp got we=%b err=%b want 0/1", regf_we, resp_err);
    else n_pass++;
    issue(0, 2, 0);
    n_checks++;
    if (outstanding !== CW'(1) || busy_rd !== 32'h0)
      $display("FAIL x0_tracked got out=%0d busy=%h want 1/0", outstanding, busy_rd);
    else n_pass++;
    respond(32'h1234);
    n_checks++;
    if (regf_we !== 1'b0 || outstanding !== CW'(0))
      $display("FAIL x0_no_write got we=%b out=%0d want 0/0", regf_we, outstanding);
    else n_pass++;
    repeat (5) cycle();
    n_checks++;
    if (resp_err !== 1'b1) $display("FAIL err_sticky got %b want 1", resp_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(1, 2, 0); issue(2, 2, 0); issue(3, 2, 0);
    dmem_resp = 1; dmem_rdata = 32'h77;
    rst = 1; cycle(); idle();
    n_checks++;
    if ({regf_we, rd_sel, rd_v, busy_rd, outstanding, resp_err} !== '0)
      $display("FAIL reset_mid got we=%b out=%0d busy=%h err=%b want all 0",
               regf_we, outstanding, busy_rd, resp_err);
    else n_pass++;
    respond(32'h77);
    n_checks++;
    if (regf_we !== 1'b0 || resp_err !== 1'b1)
      $display("FAIL resp_after_reset got we=%b err=%b want 0/1", regf_we, resp_err);
    else n_pass++;
  endtask

  task automatic test_random();
    int f3s [8];
    f3s = '{0, 1, 2, 4, 5, 0, 2, 5};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      ld_valid   = $urandom_range(0, 1);
      ld_rd      = 5'($urandom_range(0, 31));
      ld_funct3  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'(f3s[$urandom_range(0, 7)]);
      ld_addr_lo = 2'($urandom_range(0, 3));
      dmem_resp  = (mq.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      dmem_rdata = $urandom;
      alu_valid  = $urandom_range(0, 1);
      alu_rd     = 5'($urandom_range(0, 31));
      alu_data   = $urandom;
      #1;
      n_checks++;
      if (ld_ready !== (mq.size() < DEPTH) || alu_ready !== !dmem_resp)
        $display("FAIL rnd_ready cyc %0d got ld=%b alu=%b want ld=%b alu=%b",
                 c, ld_ready, alu_ready, mq.size() < DEPTH, !dmem_resp);
      else n_pass++;
      cycle();
      n_checks++;
      if ({regf_we, rd_sel, rd_v, busy_rd, outstanding, resp_err} !==
          {exp_we, exp_sel, exp_v, m_busy(), CW'(mq.size()), m_err})
        $display("FAIL rnd_state cyc %0d got we=%b sel=%0d v=%h busy=%h out=%0d err=%b want %b/%0d/%h/%h/%0d/%b",
                 c, regf_we, rd_sel, rd_v, busy_rd, outstanding, resp_err,
                 exp_we, exp_sel, exp_v, m_busy(), mq.size(), m_err);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_lb_lbu();
    test_in_order();
    test_full_wrap();
    test_arb();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
